// File: rtl/ticket_vend_ctrl.sv
// ticket_vend_ctrl
// Ticket-vending transaction controller. Validates a type/count selection,
// accumulates coin credit against the computed total, dispenses tickets one
// per cycle, then returns change. On cancel or inactivity it refunds the credit.
//
// Ports
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   sure, nsure         : confirm / cancel buttons (level, sampled each cycle)
//   ticketType          : requested ticket type (TYPE_W)
//   ticketCount         : requested ticket count (COUNT_W)
//   coinValid, coin     : one-cycle coin strobe and its value (MONEY_W)
//   paid                : running credit for the display
//   moneyReturn         : change / refund amount, valid with moneyFinish
//   moneyFinish         : one-cycle pulse, eject moneyReturn
//   ticketOut           : one pulse per dispensed ticket
//   ticketFinish        : pulse coincident with the last ticketOut
//   selErr              : pulse, selection rejected
//   coinReject          : pulse, coin refused
//   busy                : FSM is not idle
// All outputs are registered.
module ticket_vend_ctrl #(
    parameter int MONEY_W     = 8,
    parameter int TYPE_W      = 3,
    parameter int COUNT_W     = 3,
    parameter int NUM_TYPES   = 6,
    parameter int BASE_PRICE  = 5,
    parameter int PRICE_STEP  = 5,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sure,
    input  logic               nsure,
    input  logic [TYPE_W-1:0]  ticketType,
    input  logic [COUNT_W-1:0] ticketCount,
    input  logic               coinValid,
    input  logic [MONEY_W-1:0] coin,
    output logic [MONEY_W-1:0] paid,
    output logic [MONEY_W-1:0] moneyReturn,
    output logic               moneyFinish,
    output logic               ticketOut,
    output logic               ticketFinish,
    output logic               selErr,
    output logic               coinReject,
    output logic               busy
);

    // Selection total is computed wide enough that an over-range total is
    // visible rather than wrapping into a plausible value.
    localparam int TOT_W = MONEY_W + COUNT_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TOT_W-1:0] MONEY_MAX = TOT_W'((64'd1 << MONEY_W) - 64'd1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PAY    = 3'd1,
        S_DISP   = 3'd2,
        S_CHANGE = 3'd3,
        S_REFUND = 3'd4
    } state_t;

    state_t             state, state_n;
    logic [COUNT_W-1:0] cnt_q, cnt_n;      // latched ticket count
    logic [MONEY_W-1:0] total_q, total_n;  // latched price total
    logic [COUNT_W-1:0] rem_q, rem_n;      // tickets left, including this cycle's
    logic [TMO_W-1:0]   tmo_q, tmo_n;      // idle cycles spent in PAY
    logic [MONEY_W-1:0] paid_n, ret_n;
    logic               mf_n, to_n, tf_n, se_n, cr_n;

    // selection evaluation
    logic [TOT_W-1:0]   price;
    logic [TOT_W-1:0]   sel_total;
    logic               sel_ok;

    // coin accumulation
    logic [MONEY_W:0]   coin_sum;
    logic               coin_ovf;
    logic               coin_ok;
    logic [MONEY_W-1:0] paid_pay;

    always_comb begin
        price     = TOT_W'(BASE_PRICE) + TOT_W'(ticketType) * TOT_W'(PRICE_STEP);
        sel_total = price * TOT_W'(ticketCount);
        sel_ok    = (32'(ticketType) < NUM_TYPES) && (ticketCount != '0) &&
                    (sel_total <= MONEY_MAX);
    end

    always_comb begin
        coin_sum = {1'b0, paid} + {1'b0, coin};
        coin_ovf = coin_sum[MONEY_W];
        coin_ok  = coinValid && !coin_ovf;
        paid_pay = coin_ok ? coin_sum[MONEY_W-1:0] : paid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt_q        <= '0;
            total_q      <= '0;
            rem_q        <= '0;
            tmo_q        <= '0;
            paid         <= '0;
            moneyReturn  <= '0;
            moneyFinish  <= 1'b0;
            ticketOut    <= 1'b0;
            ticketFinish <= 1'b0;
            selErr       <= 1'b0;
            coinReject   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            cnt_q        <= cnt_n;
            total_q      <= total_n;
            rem_q        <= rem_n;
            tmo_q        <= tmo_n;
            paid         <= paid_n;
            moneyReturn  <= ret_n;
            moneyFinish  <= mf_n;
            ticketOut    <= to_n;
            ticketFinish <= tf_n;
            selErr       <= se_n;
            coinReject   <= cr_n;
            busy         <= (state_n != S_IDLE);
        end
    end

    // Output pulses are decided on the transition into the state in which
    // they are visible, so every output comes straight from a flop.
    always_comb begin
        state_n = state;
        cnt_n   = cnt_q;
        total_n = total_q;
        rem_n   = rem_q;
        tmo_n   = tmo_q;
        paid_n  = paid;
        ret_n   = moneyReturn;
        mf_n    = 1'b0;
        to_n    = 1'b0;
        tf_n    = 1'b0;
        se_n    = 1'b0;
        cr_n    = 1'b0;

        case (state)
            S_IDLE: begin
                if (sure) begin
                    if (sel_ok) begin
                        cnt_n   = ticketCount;
                        total_n = sel_total[MONEY_W-1:0];
                        paid_n  = '0;
                        ret_n   = '0;
                        tmo_n   = '0;
                        state_n = S_PAY;
                    end else begin
                        se_n = 1'b1;
                    end
                end
            end

            S_PAY: begin
                paid_n = paid_pay;
                cr_n   = coinValid && coin_ovf;
                if (nsure) begin
                    // a coin accepted this same cycle is part of the refund
                    state_n = S_REFUND;
                    ret_n   = paid_pay;
                    mf_n    = 1'b1;
                end else if (sure && (paid_pay >= total_q)) begin
                    state_n = S_DISP;
                    rem_n   = cnt_q;
                    to_n    = 1'b1;
                    tf_n    = (cnt_q == COUNT_W'(1));
                end else if (sure || coin_ok) begin
                    tmo_n = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_n = S_REFUND;
                    ret_n   = paid_pay;
                    mf_n    = 1'b1;
                end else begin
                    tmo_n = tmo_q + TMO_W'(1);
                end
            end

            S_DISP: begin
                // the mechanism cannot take coins while dispensing
                cr_n = coinValid;
                if (rem_q == COUNT_W'(1)) begin
                    state_n = S_CHANGE;
                    rem_n   = '0;
                    ret_n   = paid - total_q;
                    mf_n    = 1'b1;
                end else begin
                    rem_n = rem_q - COUNT_W'(1);
                    to_n  = 1'b1;
                    tf_n  = (rem_q == COUNT_W'(2));
                end
            end

            // the return value and pulse were set on entry; just close out
            S_CHANGE: state_n = S_IDLE;
            S_REFUND: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

endmodule
